morse_digit_tx: RTL and testbench
=================================

# morse_digit_tx

Serial Morse transmitter for decimal digits. Accepts one 4-bit digit per valid/ready handshake and drives the single-bit `mors` line with standard Morse timing: dot is 1 unit high, dash is 3 units high, symbol gap is 1 unit low, character gap is GAP_UNITS units low. It sits directly upstream of the Morse-to-digit decoder and generates the waveform that the decoder consumes. It is also used as a loopback stimulus source on the board.

## Interface
- UNIT_CYCLES, default 1: clk cycles per Morse unit; legal range 1..255.
- GAP_UNITS, default 7: low units after the last mark of a character; legal range 4..15.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low. Clock is clk.
- digit  in  4  digit to send; 0..9 valid.
- valid  in  1  digit present.
- ready  out  1  high only in IDLE; transfer occurs when valid && ready at a rising edge.
- mors  out  1  registered Morse line; 1 = mark.
- done  out  1  one-cycle pulse when the character gap completes.
- err  out  1  one-cycle pulse when an accepted digit is 10..15.

## Operation
- Encoding: 5 symbols, sent MSB first, with 1 = dash.
  - Digits 1..5: the first d symbols are dots and the rest are dashes. 1 = .----, 5 = .....
  - Digits 6..9: the first d-5 symbols are dashes and the rest are dots. 7 = --...
  - Digit 0 is -----.
- States and transitions:
  - IDLE: ready=1, mors=0. On accept of a valid digit, latch the pattern, set symbol index to 0, go to MARK.
  - IDLE, invalid digit: on accept of 10..15, pulse err, stay in IDLE, mors stays 0.
  - MARK: mors=1 for 1 unit (dot) or 3 units (dash). If the symbol index is below 4, go to SPACE; otherwise go to CHAR_GAP.
  - SPACE: mors=0 for 1 unit, increment the symbol index, go to MARK.
  - CHAR_GAP: mors=0 for GAP_UNITS units, then pulse done and go to IDLE.
- Counters:
  - Prescaler counts 0..UNIT_CYCLES-1 and produces a unit tick on wrap. Width is $clog2(UNIT_CYCLES+1).
  - Unit counter is 4 bits and is compared against the current state's length.
  - Symbol index is 3 bits.
  - All counters clear on every state entry; there is no wrap beyond the terminal count.
- Input capture: digit and valid are sampled only when ready=1. Changes to them while busy are ignored.
- Reset mid-operation: on the first clk edge with rst=0, state becomes IDLE, mors=0, done=0, err=0, ready=1, and all counters clear. A partially sent character is abandoned; no done pulse is issued.

## Timing
- Reset values: mors=0, ready=1, done=0, err=0.
- Accept at edge k: ready falls and mors rises after edge k.
- Mark and gap lengths are exact multiples of UNIT_CYCLES.
- Busy duration is UNIT_CYCLES × (marks + 4 + GAP_UNITS), where marks = dots + 3×dashes.
  - Example: with UNIT_CYCLES=1 and GAP_UNITS=7, digit 5 is busy 5+4+7 = 16 cycles.
  - Digit 0 is busy 15+4+7 = 26 cycles.
- done and ready=1 assert in the same cycle, at the end of CHAR_GAP.
- Back-to-back: if valid is held high, the next accept happens on the edge where done=1 and ready=1. mors rises in the following cycle, so there are no extra idle cycles.
- Invalid digit: err is high in the cycle after accept, and ready stays 1 throughout.

## Structure
- Package morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE, CHAR_GAP);
  - constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, SYMBOLS=5;
  - a digit-to-5-bit-pattern function that returns a valid flag.
- One sub-module, morse_unit_timer. It has parameter UNIT_CYCLES, inputs clk, rst and clr, and output tick (a one-cycle pulse every UNIT_CYCLES cycles after clr).
- The FSM, unit counter and symbol shifter stay in the top module.

## Test plan
- Digit 5, UNIT_CYCLES=1, GAP_UNITS=7:
  - mors = 1,0,1,0,1,0,1,0,1 followed by 0×7;
  - done in cycle 16 after accept; ready low for exactly 16 cycles.
- Digit 0, UNIT_CYCLES=1: mors = 111,0,111,0,111,0,111,0,111 then 0×7; done at cycle 26.
- Digit 7, UNIT_CYCLES=2: mors = 1×6, 0×2, 1×6, 0×2, 1×2, 0×2, 1×2, 0×2, 1×2, then 0×14.
- Digit 12 offered:
  - err pulses once; mors stays 0; ready never drops;
  - a subsequent digit 1 then transmits .---- normally.
- valid held high with digits 3 then 8: both characters are sent back-to-back. The second mors rise is one cycle after done.
- rst=0 asserted during the second dash of digit 9:
  - mors=0 and ready=1 on the next edge; no done pulse;
  - after reset, digit 9 retransmits from the first symbol.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the decimal-digit Morse transmitter.
// digit_code maps a digit to its five symbols, MSB first, 1 = dash.
package morse_pkg;

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StCharGap} state_e;

  localparam int unsigned DOT_UNITS     = 1;
  localparam int unsigned DASH_UNITS    = 3;
  localparam int unsigned SYM_GAP_UNITS = 1;
  localparam int unsigned SYMBOLS       = 5;

  typedef struct packed {
    logic               valid;
    logic [SYMBOLS-1:0] pat;
  } code_t;

  function automatic code_t digit_code(input logic [3:0] d);
    code_t c;
    c       = '0;
    c.valid = (d <= 4'd9);
    for (int i = 0; i < SYMBOLS; i++) begin
      if (d == 4'd0) begin
        c.pat[SYMBOLS-1-i] = 1'b1;
      end else if (d <= 4'd5) begin
        c.pat[SYMBOLS-1-i] = (i >= int'(d));
      end else begin
        c.pat[SYMBOLS-1-i] = (i < int'(d) - 5);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: tick_o pulses once every UNIT_CYCLES cycles after clr_i drops.
// With UNIT_CYCLES=1 the tick is permanently high.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(UNIT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntW'(UNIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/morse_digit_tx.sv
// Morse transmitter for decimal digits: one digit per valid/ready handshake,
// driven onto a registered mors line with dot/dash/gap timing in units.
module morse_digit_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1,
  parameter int unsigned GAP_UNITS   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       mors_o,
  output logic       done_o,
  output logic       err_o
);

  state_e             state_q;
  logic [SYMBOLS-1:0] pat_q;
  logic [3:0]         unit_q;
  logic [2:0]         idx_q;
  logic               ready_q, mors_q, done_q, err_q;

  logic       tick, clr, last_unit;
  logic [3:0] len;
  code_t      code;

  assign code = digit_code(digit_i);

  always_comb begin
    len = 4'(SYM_GAP_UNITS);
    case (state_q)
      StMark:    len = pat_q[SYMBOLS-1] ? 4'(DASH_UNITS) : 4'(DOT_UNITS);
      StCharGap: len = 4'(GAP_UNITS);
      default:   len = 4'(SYM_GAP_UNITS);
    endcase
  end

  assign last_unit = tick && (unit_q == len - 4'd1);
  // Restart the prescaler on every state entry so each state lasts whole units.
  assign clr       = (state_q == StIdle) || last_unit;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      mors_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (tick) unit_q <= unit_q + 4'd1;
      case (state_q)
        StIdle: begin
          unit_q <= '0;
          if (valid_i) begin
            if (code.valid) begin
              pat_q   <= code.pat;
              idx_q   <= '0;
              mors_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= StMark;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StMark: begin
          if (last_unit) begin
            unit_q  <= '0;
            mors_q  <= 1'b0;
            state_q <= (idx_q < 3'(SYMBOLS - 1)) ? StSpace : StCharGap;
          end
        end
        StSpace: begin
          if (last_unit) begin
            unit_q  <= '0;
            idx_q   <= idx_q + 3'd1;
            pat_q   <= {pat_q[SYMBOLS-2:0], 1'b0};
            mors_q  <= 1'b1;
            state_q <= StMark;
          end
        end
        StCharGap: begin
          if (last_unit) begin
            unit_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign mors_o  = mors_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_morse_digit_tx.sv
// Bench for morse_digit_tx: two instances (1 and 2 cycles per unit), checked
// cycle by cycle against a waveform built from the dot/dash code strings.
module tb_morse_digit_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_r [2];
  logic       valid_r [2];
  logic       ready_w [2];
  logic       mors_w  [2];
  logic       done_w  [2];
  logic       err_w   [2];

  int checks   = 0;
  int failures = 0;

  bit    exp_q[$];
  string codes [10];

  always #5 clk = ~clk;

  morse_digit_tx #(.UNIT_CYCLES(1), .GAP_UNITS(7)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .digit_i(digit_r[0]),
    .valid_i(valid_r[0]),
    .ready_o(ready_w[0]),
    .mors_o (mors_w[0]),
    .done_o (done_w[0]),
    .err_o  (err_w[0])
  );

  morse_digit_tx #(.UNIT_CYCLES(2), .GAP_UNITS(7)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .digit_i(digit_r[1]),
    .valid_i(valid_r[1]),
    .ready_o(ready_w[1]),
    .mors_o (mors_w[1]),
    .done_o (done_w[1]),
    .err_o  (err_w[1])
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  function automatic int uc_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  // Expected mors level for every busy cycle of one character.
  function automatic void build(input int d, input int uc, input int gap);
    string c;
    int    len;
    c = codes[d];
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      len = (c[i] == "-") ? 3 : 1;
      repeat (len * uc) exp_q.push_back(1'b1);
      if (i < 4) repeat (uc) exp_q.push_back(1'b0);
    end
    repeat (gap * uc) exp_q.push_back(1'b0);
  endfunction

  // Called just after a negedge with the instance idle. With hold set, valid
  // stays high carrying nxt, so the next character is accepted on done.
  task automatic send(input int s, input int d, input int busy, input bit hold,
                      input logic [3:0] nxt);
    int n_low;
    int n;
    chk("ready_before_accept", int'(ready_w[s]), 1);
    digit_r[s] = 4'(d);
    valid_r[s] = 1'b1;
    @(negedge clk);
    if (hold) digit_r[s] = nxt;
    else valid_r[s] = 1'b0;
    if (d > 9) begin
      chk("invalid_err", int'(err_w[s]), 1);
      chk("invalid_ready", int'(ready_w[s]), 1);
      chk("invalid_mors", int'(mors_w[s]), 0);
      @(negedge clk);
      chk("invalid_err_clear", int'(err_w[s]), 0);
      chk("invalid_ready_after", int'(ready_w[s]), 1);
      return;
    end
    build(d, uc_of(s), 7);
    n     = exp_q.size();
    n_low = 0;
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge clk);
      chk("mors", int'(mors_w[s]), int'(exp_q[j]));
      chk("ready_busy", int'(ready_w[s]), 0);
      chk("done_busy", int'(done_w[s]), 0);
      chk("err_busy", int'(err_w[s]), 0);
      if (!ready_w[s]) n_low++;
      if (!hold) begin
        // Input activity while busy must be ignored.
        digit_r[s] = 4'($urandom_range(0, 15));
        valid_r[s] = (j < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", int'(done_w[s]), 1);
    chk("ready_at_done", int'(ready_w[s]), 1);
    chk("mors_at_done", int'(mors_w[s]), 0);
    chk("busy_cycles", n_low, (busy >= 0) ? busy : n);
    if (!hold) begin
      @(negedge clk);
      chk("done_single", int'(done_w[s]), 0);
      chk("idle_mors", int'(mors_w[s]), 0);
    end
  endtask

  typedef struct {
    int s;
    int d;
    int busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n_done;
    codes = '{"-----", ".----", "..---", "...--", "....-",
              ".....", "-....", "--...", "---..", "----."};
    tbl = '{'{0, 5, 16}, '{0, 0, 26}, '{1, 7, 40}, '{0, 12, 0},
            '{0, 1, 24}, '{1, 2, 44}, '{0, 9, 24}, '{1, 15, 0}};
    for (int s = 0; s < 2; s++) begin
      digit_r[s] = 4'd0;
      valid_r[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", int'(ready_w[s]), 1);
      chk("reset_mors", int'(mors_w[s]), 0);
      chk("reset_done", int'(done_w[s]), 0);
      chk("reset_err", int'(err_w[s]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].s, tbl[i].d, tbl[i].busy, 1'b0, 4'd0);
    end

    // Back-to-back with valid held: second mark starts right after done.
    send(0, 3, 20, 1'b1, 4'd8);
    send(0, 8, 22, 1'b0, 4'd0);

    // Reset during the second dash of digit 9.
    chk("ready_before_accept", int'(ready_w[0]), 1);
    digit_r[0] = 4'd9;
    valid_r[0] = 1'b1;
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_dash_mors", int'(mors_w[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mors", int'(mors_w[0]), 0);
    chk("midrst_ready", int'(ready_w[0]), 1);
    chk("midrst_done", int'(done_w[0]), 0);
    rst    = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_w[0] || !ready_w[0] || mors_w[0]) n_done++;
    end
    chk("midrst_quiet", n_done, 0);
    send(0, 9, 24, 1'b0, 4'd0);

    // Random digits on random instances against the model.
    for (int k = 0; k < 16; k++) begin
      int s;
      s = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(s, int'($urandom_range(0, 15)), -1, 1'b0, 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
